// File: rtl/con_loader_pkg.sv
// rtl/con_loader_pkg.sv - shared state encoding and frame constants for the console loader
package con_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN0,
      LEN1,
      DATA,
      WRITE,
      VERIFY,
      DONE
   } state_e;

   // Length header is a little-endian 16-bit word count; payload words are 4 bytes each.
   localparam int LEN_BYTES  = 2;
   localparam int WORD_BYTES = 4;

endpackage

// File: rtl/con_loader_if.sv
// rtl/con_loader_if.sv - byte stream input and console write/read port bundle
interface con_loader_if #(
   parameter int ADDR_W = 10,
   parameter int WORD_W = 32
) ();

   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic [3:0]        con_write;
   logic [ADDR_W-1:0] con_addr;
   logic [WORD_W-1:0] con_in;
   logic [WORD_W-1:0] con_out;

   // Loader side: consumes the byte stream and drives the core's console port.
   modport master (
      input  in_valid, in_data, con_out,
      output in_ready, con_write, con_addr, con_in
   );

   // Environment side: byte source plus the core memory.
   modport slave (
      output in_valid, in_data, con_out,
      input  in_ready, con_write, con_addr, con_in
   );

endinterface

// File: rtl/con_readback_sum.sv
// rtl/con_readback_sum.sv - read-latency valid pipe and readback checksum accumulator
module con_readback_sum #(
   parameter int RD_LAT = 1,
   parameter int WORD_W = 32
) (
   input  logic              CLK,
   input  logic              nrst,
   input  logic              clr,
   input  logic              issue,
   input  logic [WORD_W-1:0] rdata,
   output logic [WORD_W-1:0] sum,
   output logic              last
);

   logic [RD_LAT-1:0] vld_q, vld_d;
   logic [RD_LAT:0]   chain;
   logic [WORD_W-1:0] sum_q, sum_d;

   assign chain = {vld_q, issue};

   // Sum already includes the word returning this cycle, so the caller can
   // compare it on the same cycle that last fires.
   assign sum  = sum_q + (vld_q[RD_LAT-1] ? rdata : '0);

   // Returns are contiguous, so the final one is where the pipe output drops behind it.
   assign last = chain[RD_LAT] & ~chain[RD_LAT-1];

   // Shift the issue strobe toward the data-valid tap and accumulate returns.
   always_comb begin
      vld_d = chain[RD_LAT-1:0];
      sum_d = sum;
      if (clr) begin
         vld_d = '0;
         sum_d = '0;
      end
   end

   // Pipe and accumulator registers.
   always_ff @(posedge CLK or negedge nrst) begin
      if (!nrst) begin
         vld_q <= '0;
         sum_q <= '0;
      end else begin
         vld_q <= vld_d;
         sum_q <= sum_d;
      end
   end

endmodule

// File: rtl/con_loader.sv
// rtl/con_loader.sv - preloads core memory from a byte stream, verifies by readback checksum
module con_loader
   import con_loader_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int WORD_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic         CLK,
   input  logic         nrst,
   input  logic         start,
   con_loader_if.master bus,
   output logic         core_nrst,
   output logic         busy,
   output logic         done,
   output logic         verify_fail,
   output logic         ovf
);

   localparam int              CNT_W = LEN_BYTES * 8;
   localparam logic [CNT_W:0]  DEPTH = {{CNT_W{1'b0}}, 1'b1} << ADDR_W;
   localparam logic [CNT_W-1:0] ONE  = 1;
   localparam logic [CNT_W:0]  ONE_W = 1;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  len_q, len_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W:0]    iss_cnt_q, iss_cnt_d;
   logic [1:0]        byte_idx_q, byte_idx_d;
   logic [WORD_W-1:0] word_q, word_d;
   logic [WORD_W-1:0] sum_wr_q, sum_wr_d;
   logic              issue_q, issue_d;
   logic              ovf_q, ovf_d;
   logic              vf_q, vf_d;
   logic              done_q, done_d;
   logic              core_nrst_q, core_nrst_d;
   logic              busy_q, busy_d;
   logic              in_ready_q, in_ready_d;
   logic [3:0]        con_write_q, con_write_d;
   logic [ADDR_W-1:0] con_addr_q, con_addr_d;
   logic [WORD_W-1:0] con_in_q, con_in_d;

   logic              hs, last_word, in_range, enter_verify, rb_clr, rb_last;
   logic [CNT_W:0]    m_words;
   logic [WORD_W-1:0] word_asm, rb_sum;

   assign hs        = bus.in_valid & in_ready_q;
   assign last_word = (cnt_q == len_q - ONE);
   assign in_range  = ({1'b0, cnt_q} < DEPTH);
   assign m_words   = ({1'b0, len_q} < DEPTH) ? {1'b0, len_q} : DEPTH;

   con_readback_sum #(.RD_LAT(RD_LAT), .WORD_W(WORD_W)) u_rb (
      .CLK   (CLK),
      .nrst  (nrst),
      .clr   (rb_clr),
      .issue (issue_q),
      .rdata (bus.con_out),
      .sum   (rb_sum),
      .last  (rb_last)
   );

   // Next-state and next-output computation for the load/verify sequence.
   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      cnt_d        = cnt_q;
      iss_cnt_d    = iss_cnt_q;
      byte_idx_d   = byte_idx_q;
      word_d       = word_q;
      sum_wr_d     = sum_wr_q;
      issue_d      = issue_q;
      ovf_d        = ovf_q;
      vf_d         = vf_q;
      con_write_d  = 4'h0;
      con_addr_d   = con_addr_q;
      con_in_d     = con_in_q;
      enter_verify = 1'b0;
      rb_clr       = 1'b0;
      word_asm     = word_q;
      word_asm[8*byte_idx_q +: 8] = bus.in_data;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d    = LEN0;
               cnt_d      = '0;
               byte_idx_d = '0;
               sum_wr_d   = '0;
               ovf_d      = 1'b0;
               vf_d       = 1'b0;
               rb_clr     = 1'b1;
            end
         end
         LEN0: begin
            if (hs) begin
               len_d[7:0] = bus.in_data;
               state_d    = LEN1;
            end
         end
         LEN1: begin
            if (hs) begin
               len_d[15:8] = bus.in_data;
               state_d     = ({bus.in_data, len_q[7:0]} == '0) ? DONE : DATA;
            end
         end
         DATA: begin
            if (hs) begin
               word_d     = word_asm;
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'(WORD_BYTES - 1)) begin
                  if (in_range) begin
                     state_d     = WRITE;
                     con_write_d = 4'hF;
                     con_addr_d  = cnt_q[ADDR_W-1:0];
                     con_in_d    = word_asm;
                     sum_wr_d    = sum_wr_q + word_asm;
                  end else begin
                     // Beyond memory depth: drain the word but never write or sum it.
                     ovf_d        = 1'b1;
                     cnt_d        = cnt_q + ONE;
                     enter_verify = last_word;
                  end
               end
            end
         end
         WRITE: begin
            cnt_d        = cnt_q + ONE;
            enter_verify = last_word;
            if (!last_word) state_d = DATA;
         end
         VERIFY: begin
            if (issue_q) begin
               if (iss_cnt_q < m_words) begin
                  con_addr_d = iss_cnt_q[ADDR_W-1:0];
                  iss_cnt_d  = iss_cnt_q + ONE_W;
               end else begin
                  issue_d = 1'b0;
               end
            end
            if (rb_last) begin
               state_d = DONE;
               vf_d    = (sum_wr_q != rb_sum);
            end
         end
         default: state_d = IDLE;
      endcase

      if (enter_verify) begin
         state_d    = VERIFY;
         con_addr_d = '0;
         issue_d    = 1'b1;
         iss_cnt_d  = ONE_W;
      end

      in_ready_d  = (state_d == LEN0) || (state_d == LEN1) || (state_d == DATA);
      busy_d      = !((state_d == IDLE) || (state_d == DONE));
      done_d      = (state_d == DONE);
      core_nrst_d = (state_d == DONE);
   end

   // State and registered outputs; reset discards any partial word or pending write.
   always_ff @(posedge CLK or negedge nrst) begin
      if (!nrst) begin
         state_q     <= IDLE;
         len_q       <= '0;
         cnt_q       <= '0;
         iss_cnt_q   <= '0;
         byte_idx_q  <= '0;
         word_q      <= '0;
         sum_wr_q    <= '0;
         issue_q     <= 1'b0;
         ovf_q       <= 1'b0;
         vf_q        <= 1'b0;
         done_q      <= 1'b0;
         core_nrst_q <= 1'b0;
         busy_q      <= 1'b0;
         in_ready_q  <= 1'b0;
         con_write_q <= 4'h0;
         con_addr_q  <= '0;
         con_in_q    <= '0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         iss_cnt_q   <= iss_cnt_d;
         byte_idx_q  <= byte_idx_d;
         word_q      <= word_d;
         sum_wr_q    <= sum_wr_d;
         issue_q     <= issue_d;
         ovf_q       <= ovf_d;
         vf_q        <= vf_d;
         done_q      <= done_d;
         core_nrst_q <= core_nrst_d;
         busy_q      <= busy_d;
         in_ready_q  <= in_ready_d;
         con_write_q <= con_write_d;
         con_addr_q  <= con_addr_d;
         con_in_q    <= con_in_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.con_write = con_write_q;
   assign bus.con_addr  = con_addr_q;
   assign bus.con_in    = con_in_q;
   assign core_nrst     = core_nrst_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign verify_fail   = vf_q;
   assign ovf           = ovf_q;

endmodule
